// File: rtl/spi_btn_pkg.sv
// Shared types and helpers for the SPI button-frame reader.
// Holds the FSM state enum, frame size and the responder bit-order remap.
package spi_btn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_e;

  localparam int C_BITS = 8;

  // Responder shifts b0 first, then b7 down to b1.
  function automatic int slot2bit(input int k);
    return (k == 0) ? 0 : C_BITS - k;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_btn_tick.sv
// SCLK half-period tick generator for spi_btn_reader.
// Counter held at zero by i_clr; ticks on count C_clk_div-1.
module spi_btn_tick
  import spi_btn_pkg::*;
#(
  parameter int C_clk_div = 4
) (
  input  logic i_clk,
  input  logic i_resetn,
  input  logic i_clr,
  output logic o_tick
);

  localparam int TW = cnt_w(C_clk_div);
  localparam logic [TW-1:0] LAST = TW'(C_clk_div - 1);

  logic [TW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  assign o_tick = w_last && !i_clr;

  always_ff @(posedge i_clk) begin
    if (!i_resetn || i_clr || w_last)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/spi_btn_reader.sv
// SPI initiator polling the OLED-SPI button responder frame.
// Define SPI_BTN_DEBOUNCE_EN to commit only two identical frames in a row.
module spi_btn_reader
  import spi_btn_pkg::*;
#(
  parameter int C_clk_div     = 4,
  parameter int C_bits        = C_BITS,
  parameter int C_poll_period = 250000
) (
  input  logic       clk_25mhz,
  input  logic       resetn,
  input  logic       start,
  output logic       spi_csn,
  output logic       spi_clk,
  input  logic       spi_miso,
  output logic [7:0] data,
  output logic       valid,
  output logic       busy
);

  localparam int IW = cnt_w(C_bits);
  localparam int PW = cnt_w(C_poll_period + 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(C_bits - 1);
  localparam logic [PW-1:0] POLL_LAST =
    PW'((C_poll_period > 0) ? C_poll_period - 1 : 0);

  state_e              r_state;
  state_e              w_state_nxt;
  logic                w_tick;
  logic                w_go;
  logic                w_fin;
  logic                w_poll_hit;
  logic [PW-1:0]       r_poll;
  logic [IW-1:0]       r_idx;
  logic                r_miso_s1;
  logic                r_miso_s2;
  logic [C_bits-1:0]   r_slot;
  logic [7:0]          w_frame;
`ifdef SPI_BTN_DEBOUNCE_EN
  logic [7:0]          r_cand;
`endif

  spi_btn_tick #(
    .C_clk_div(C_clk_div)
  ) u_tick (
    .i_clk   (clk_25mhz),
    .i_resetn(resetn),
    .i_clr   (r_state == IDLE),
    .o_tick  (w_tick)
  );

  assign w_poll_hit = (C_poll_period > 0) && (r_poll == POLL_LAST);
  assign w_go  = (r_state == IDLE) && (start || w_poll_hit);
  assign w_fin = (r_state == HIGH) && w_tick && (r_idx == IDX_LAST);

  always_comb begin
    w_frame = '0;
    for (int k = 0; k < C_bits; k++)
      w_frame[3'(slot2bit(k))] = r_slot[IW'(k)];
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (w_go) w_state_nxt = LOW;
      LOW:  if (w_tick) w_state_nxt = HIGH;
      HIGH: if (w_tick) w_state_nxt = w_fin ? DONE : LOW;
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_25mhz) begin
    if (!resetn)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_25mhz) begin
    if (!resetn || w_go || C_poll_period == 0)
      r_poll <= '0;
    else if (r_state == IDLE)
      r_poll <= r_poll + 1'b1;
  end

  // Pins are registered from the next state so they align with r_state.
  always_ff @(posedge clk_25mhz) begin
    if (!resetn) begin
      r_miso_s1 <= 1'b0;
      r_miso_s2 <= 1'b0;
      spi_csn   <= 1'b1;
      spi_clk   <= 1'b0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      data      <= '0;
      r_idx     <= '0;
      r_slot    <= '0;
`ifdef SPI_BTN_DEBOUNCE_EN
      r_cand    <= '0;
`endif
    end else begin
      r_miso_s1 <= spi_miso;
      r_miso_s2 <= r_miso_s1;
      spi_csn   <= !(w_state_nxt == LOW || w_state_nxt == HIGH);
      spi_clk   <= (w_state_nxt == HIGH);
      busy      <= (w_state_nxt != IDLE);
      valid     <= 1'b0;
      if (w_go)
        r_idx <= '0;
      else if (r_state == HIGH && w_tick && r_idx != IDX_LAST)
        r_idx <= r_idx + 1'b1;
      if (r_state == LOW && w_tick)
        r_slot[r_idx] <= r_miso_s2;
      if (w_fin) begin
`ifdef SPI_BTN_DEBOUNCE_EN
        if (w_frame == r_cand) begin
          data  <= w_frame;
          valid <= 1'b1;
        end
        r_cand <= w_frame;
`else
        data  <= w_frame;
        valid <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_spi_btn_reader.sv
// Bench for spi_btn_reader: responder model, frame-level reference and vectors.
// Honours SPI_BTN_DEBOUNCE_EN when defined for the build.
module tb_spi_btn_reader;

  localparam int DIV = 4;
  localparam int NB  = 8;
  localparam int P   = 200;
  localparam int FL  = 2 * NB * DIV;

  logic       clk = 0;
  logic       resetn = 0;
  logic       start = 0;
  logic       spi_csn, spi_clk, spi_miso;
  logic [7:0] data;
  logic       valid, busy;

  logic [6:0] btn = 7'h53;
  logic       frc = 0;
  logic [7:0] r_resp = 0;
  logic       r_pclk = 0;

  int chk = 0;
  int err = 0;
  int cyc = 0;
  bit chk_on = 0;

  spi_btn_reader #(
    .C_clk_div(DIV),
    .C_bits(NB),
    .C_poll_period(P)
  ) dut (
    .clk_25mhz(clk),
    .resetn(resetn),
    .start(start),
    .spi_csn(spi_csn),
    .spi_clk(spi_clk),
    .spi_miso(spi_miso),
    .data(data),
    .valid(valid),
    .busy(busy)
  );

  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Responder: loads {0,btn} while CSn high, rotates left per SCLK rise.
  always @(posedge clk) begin
    r_pclk <= spi_clk;
    if (spi_csn)
      r_resp <= {1'b0, btn};
    else if (spi_clk && !r_pclk)
      r_resp <= {r_resp[6:0], r_resp[7]};
  end
  assign spi_miso = frc ? 1'b1 : r_resp[0];

  // Frame-level reference: t counts cycles into the frame.
  bit         m_busy = 0;
  int         m_t = 0;
  int         m_idle = 0;
  logic [7:0] m_fr = 0, m_data = 0, m_cand = 0;
  logic       m_valid = 0;

  always @(posedge clk) begin
    if (!resetn) begin
      m_busy = 0; m_t = 0; m_idle = 0;
      m_data = 0; m_cand = 0; m_valid = 0;
    end else begin
      m_valid = 0;
      if (!m_busy) begin
        if (start || (P > 0 && m_idle == P - 1)) begin
          m_busy = 1; m_t = 0; m_idle = 0;
          m_fr = frc ? 8'hFF : {1'b0, btn};
        end else begin
          m_idle = m_idle + 1;
        end
      end else if (m_t == FL) begin
        m_busy = 0; m_idle = 0;
      end else begin
        m_t = m_t + 1;
        if (m_t == FL) begin
`ifdef SPI_BTN_DEBOUNCE_EN
          if (m_fr == m_cand) begin
            m_data = m_fr; m_valid = 1;
          end
          m_cand = m_fr;
`else
          m_data = m_fr; m_valid = 1;
`endif
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [11:0] e, a;
    logic act_low;
    if (chk_on) begin
      act_low = m_busy && m_t < FL;
      e = {!act_low, act_low && ((m_t / DIV) % 2 == 1),
           m_busy, m_valid, m_data};
      a = {spi_csn, spi_clk, busy, valid, data};
      chk++;
      if (a !== e) begin
        err++;
        if (err < 20)
          $display("FAIL cycle_model @%0d: got %h expected %h", cyc, a, e);
      end
    end
  end

  task automatic tk();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    chk++;
    err++;
    $display("FAIL %s: timeout", nm);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 1000) begin tk(); n++; end
    if (n == 1000) timeout("wait_idle");
  endtask

  task automatic do_frame(output logic got, output logic [7:0] gd);
    int n = 0;
    got = 0; gd = 0;
    wait_idle();
    start = 1; tk(); start = 0;
    while (n < 200) begin
      tk(); n++;
      if (valid) begin got = 1; gd = data; end
      if (!busy) break;
    end
    if (n == 200) timeout("do_frame");
  endtask

  typedef struct {
    logic [6:0] b;
    logic       f;
    logic [7:0] x;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic       g;
    logic [7:0] d;
    int lowc, rises, vc, n;
    int t1, t2, t3;
    logic pc, pcs;

    tbl[0] = '{7'h53, 1'b0, 8'h53};
    tbl[1] = '{7'h7F, 1'b0, 8'h7F};
    tbl[2] = '{7'h00, 1'b1, 8'hFF};
    tbl[3] = '{7'h01, 1'b0, 8'h01};
    tbl[4] = '{7'h02, 1'b0, 8'h02};
    tbl[5] = '{7'h40, 1'b0, 8'h40};
    tbl[6] = '{7'h2A, 1'b0, 8'h2A};

    tk(); tk(); tk();
    chk_on = 1;
    check("rst_csn", spi_csn, 1);
    check("rst_clk", spi_clk, 0);
    check("rst_data", data, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    resetn = 1;

    // Single frame started at cycle 10
    while (cyc < 10) tk();
    start = 1; tk(); start = 0;
    lowc = 0; rises = 0; vc = 0; pc = 0; d = 0; n = 0;
    while (n < 100) begin
      if (!spi_csn) lowc++;
      if (spi_clk && !pc) rises++;
      pc = spi_clk;
      if (valid) begin vc++; d = data; end
      if (spi_csn && lowc > 0) break;
      tk(); n++;
    end
    if (n == 100) timeout("frame1");
    check("frame1_csn_low", lowc, FL);
    check("frame1_rises", rises, NB);
`ifdef SPI_BTN_DEBOUNCE_EN
    check("frame1_valid_cnt", vc, 0);
    do_frame(g, d);
    check("frame1b_valid", g, 1);
`else
    check("frame1_valid_cnt", vc, 1);
`endif
    check("frame1_data", d, 8'h53);

    for (int i = 0; i < 7; i++) begin
      wait_idle();
      btn = tbl[i].b; frc = tbl[i].f;
`ifdef SPI_BTN_DEBOUNCE_EN
      do_frame(g, d);
      check($sformatf("vec%0d_first_novalid", i), g, 0);
`endif
      do_frame(g, d);
      check($sformatf("vec%0d_valid", i), g, 1);
      check($sformatf("vec%0d_data", i), d, tbl[i].x);
    end
    frc = 0;

    // Auto-poll: spacing is idle period plus full frame
    wait_idle();
    btn = 7'h7F;
    t1 = 0; t2 = 0; t3 = 0; pcs = spi_csn; n = 0;
    while (t3 == 0 && n < 1200) begin
      tk(); n++;
      if (pcs && !spi_csn) begin
        if (t1 == 0) t1 = cyc;
        else if (t2 == 0) t2 = cyc;
        else t3 = cyc;
      end
      pcs = spi_csn;
    end
    if (t3 == 0) timeout("poll");
    check("poll_gap1", t2 - t1, P + FL + 1);
    check("poll_gap2", t3 - t2, P + FL + 1);
    wait_idle();
    check("poll_data", data, 8'h7F);

    // start held through a frame
    start = 1; tk();
    lowc = 0; n = 0;
    while (!spi_csn && n < 200) begin lowc++; tk(); n++; end
    check("held_csn_low", lowc, FL);
    check("held_valid", valid, 1);
    start = 0;
    tk();
    check("held_no_restart", busy, 0);

    // Reset at the 3rd SCLK rise
    btn = 7'h53;
    wait_idle();
    start = 1; tk(); start = 0;
    rises = 0; pc = 0; n = 0;
    while (rises < 3 && n < 100) begin
      if (spi_clk && !pc) rises++;
      pc = spi_clk;
      if (rises < 3) begin tk(); n++; end
    end
    if (n == 100) timeout("rst_mid");
    resetn = 0; tk();
    check("midrst_csn", spi_csn, 1);
    check("midrst_clk", spi_clk, 0);
    check("midrst_data", data, 0);
    resetn = 1; tk();
`ifdef SPI_BTN_DEBOUNCE_EN
    do_frame(g, d);
`endif
    do_frame(g, d);
    check("post_rst_valid", g, 1);
    check("post_rst_data", d, 8'h53);

    // Random starts and button changes against the reference
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 63) == 0) btn = 7'($urandom);
      tk();
    end
    start = 0;
    wait_idle();
    tk();

    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

endmodule
